rect_fill_arbiter: RTL

Shares the single pixel-buffer write port of the `squares` system between two rectangle-fill requesters: port 0 is the screen-clear engine and port 1 is the square renderer. Each accepted request is a solid-colour rectangle. The block sequences that rectangle into row-major single-pixel writes on an Avalon-MM-style write master. Arbitration is round-robin, one rectangle at a time, and a completion pulse identifies the finished requester. It sits between the game logic and the pixel-buffer slave that feeds the VGA path.

---
 rtl/rect_fill_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/rect_fill_arbiter.sv
// rect_fill_arbiter: round-robin arbiter between the screen-clear engine
// (port 0) and the square renderer (port 1). Each accepted solid-colour
// rectangle is streamed as row-major single-pixel writes on an
// Avalon-MM-style write master. A one-cycle done pulse names the owner.

// Per-port far-corner clip and empty detection, kept separate so the
// arbiter only has to mux already-clipped bounds.
module rect_fill_clip #(
  parameter int X_W   = 9,
  parameter int Y_W   = 8,
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  output logic [X_W-1:0] x1c,
  output logic [Y_W-1:0] y1c,
  output logic           empty
);
  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

  // Clip the far corner to the visible area; an inverted or fully
  // off-screen rectangle collapses to zero pixels.
  always_comb begin
    x1c   = (x1 > X_MAX) ? X_MAX : x1;
    y1c   = (y1 > Y_MAX) ? Y_MAX : y1;
    empty = (x0 > x1c) || (y0 > y1c);
  end
endmodule

module rect_fill_arbiter #(
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int COLOR_W = 16
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [X_W-1:0]       req0_x0,
  input  logic [X_W-1:0]       req0_x1,
  input  logic [Y_W-1:0]       req0_y0,
  input  logic [Y_W-1:0]       req0_y1,
  input  logic [COLOR_W-1:0]   req0_color,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [X_W-1:0]       req1_x0,
  input  logic [X_W-1:0]       req1_x1,
  input  logic [Y_W-1:0]       req1_y0,
  input  logic [Y_W-1:0]       req1_y1,
  input  logic [COLOR_W-1:0]   req1_color,
  output logic                 fb_write,
  output logic [X_W+Y_W-1:0]   fb_address,
  output logic [COLOR_W-1:0]   fb_writedata,
  input  logic                 fb_waitrequest,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id
);
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  typedef struct packed {
    logic [X_W-1:0]     x0;
    logic [X_W-1:0]     x1c;
    logic [Y_W-1:0]     y0;
    logic [Y_W-1:0]     y1c;
    logic [COLOR_W-1:0] color;
    logic               empty;
  } rect_t;

  state_t state;
  logic   last_grant;
  logic   owner;

  logic [X_W-1:0] x0_q;
  logic [X_W-1:0] x1c_q;
  logic [Y_W-1:0] y1c_q;

  logic [NUM_PORTS-1:0][X_W-1:0]     x0_v, x1_v, x1c_v;
  logic [NUM_PORTS-1:0][Y_W-1:0]     y0_v, y1_v, y1c_v;
  logic [NUM_PORTS-1:0][COLOR_W-1:0] color_v;
  logic [NUM_PORTS-1:0]              empty_v;

  rect_t win;
  logic  win_id;
  logic  accept;
  logic  idle;

  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;

  assign x0_v    = {req1_x0, req0_x0};
  assign x1_v    = {req1_x1, req0_x1};
  assign y0_v    = {req1_y0, req0_y0};
  assign y1_v    = {req1_y1, req0_y1};
  assign color_v = {req1_color, req0_color};

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_clip
      rect_fill_clip #(
        .X_W(X_W), .Y_W(Y_W), .H_RES(H_RES), .V_RES(V_RES)
      ) u_clip (
        .x0   (x0_v[g]),
        .x1   (x1_v[g]),
        .y0   (y0_v[g]),
        .y1   (y1_v[g]),
        .x1c  (x1c_v[g]),
        .y1c  (y1c_v[g]),
        .empty(empty_v[g])
      );
    end
  endgenerate

  // Grant only in IDLE and never during reset; on a tie the port that
  // did not win last time goes first.
  always_comb begin
    idle       = (state == IDLE) && !reset_reset;
    req0_ready = idle && req0_valid && (!req1_valid || last_grant);
    req1_ready = idle && req1_valid && (!req0_valid || !last_grant);
    accept     = req0_ready || req1_ready;
    win_id     = req1_ready;
  end

  // Select the winning port's clipped rectangle.
  always_comb begin
    win.x0    = x0_v[win_id];
    win.x1c   = x1c_v[win_id];
    win.y0    = y0_v[win_id];
    win.y1c   = y1c_v[win_id];
    win.color = color_v[win_id];
    win.empty = empty_v[win_id];
  end

  // The live address register doubles as the pixel cursor.
  assign cx = fb_address[X_W-1:0];
  assign cy = fb_address[X_W +: Y_W];

  // Sequencer: accept a rectangle, walk it row-major holding the bus
  // stable under waitrequest, then emit the one-cycle completion pulse.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      x0_q         <= '0;
      x1c_q        <= '0;
      y1c_q        <= '0;
      fb_write     <= 1'b0;
      fb_address   <= '0;
      fb_writedata <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_id      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= win_id;
            last_grant <= win_id;
            x0_q       <= win.x0;
            x1c_q      <= win.x1c;
            y1c_q      <= win.y1c;
            busy       <= 1'b1;
            if (win.empty) begin
              state   <= DONE;
              done    <= 1'b1;
              done_id <= win_id;
            end else begin
              state        <= FILL;
              fb_write     <= 1'b1;
              fb_address   <= {win.y0, win.x0};
              fb_writedata <= win.color;
            end
          end
        end
        FILL: begin
          if (!fb_waitrequest) begin
            if (cx < x1c_q) begin
              fb_address[X_W-1:0] <= cx + 1'b1;
            end else if (cy < y1c_q) begin
              fb_address <= {cy + 1'b1, x0_q};
            end else begin
              fb_write <= 1'b0;
              state    <= DONE;
              done     <= 1'b1;
              done_id  <= owner;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
